seg_memory: RTL and testbench
=============================

SEG_MEMORY -- requirements
Module: seg_memory

Interface
REQ-001 SHALL have parameter NB_ADDR, default 32, PC and byte-address width.
REQ-002 SHALL have parameter NB_DATA, default 32, datapath width.
REQ-003 SHALL have parameter NB_CTRL_WB, default 2, write-back control width.
REQ-004 SHALL have parameter NB_CTRL_M, default 3, memory control width.
REQ-005 SHALL have parameter RAM_DEPTH, default 256, data memory depth in words (power of 2).
REQ-006 SHALL have one clock; reset is synchronous and active-low.
REQ-007 i_clk  in  1  clock, all state updates on rising edge.
REQ-008 i_rst  in  1  synchronous active-low reset.
REQ-009 i_enable  in  1  pipeline advance; 0 holds all registered outputs and suppresses writes.
REQ-010 i_PC  in  NB_ADDR  branch target from execute stage.
REQ-011 i_ALU_result  in  NB_DATA  ALU result and memory byte address.
REQ-012 i_ALU_zero  in  1  ALU zero flag.
REQ-013 i_read_data_2  in  NB_DATA  store data.
REQ-014 i_write_reg  in  5  destination register index.
REQ-015 i_control  in  NB_CTRL_WB+NB_CTRL_M  bit4 RegWrite, bit3 MemtoReg, bit2 Branch, bit1 MemRead, bit0 MemWrite.
REQ-016 o_PCSrc  out  1  branch taken.
REQ-017 o_branch_PC  out  NB_ADDR  branch target to fetch.
REQ-018 o_read_data  out  NB_DATA  registered load data.
REQ-019 o_ALU_result  out  NB_DATA  registered ALU result.
REQ-020 o_write_reg  out  5  registered destination index.
REQ-021 o_control  out  NB_CTRL_WB  registered {RegWrite, MemtoReg}.
REQ-022 o_mem_fault  out  1  registered one-cycle fault pulse.
REQ-023 o_ready  out  1  high when memory initialisation is complete.

Function
REQ-024 o_PCSrc SHALL be combinational: Branch AND i_ALU_zero AND o_ready; o_branch_PC SHALL equal i_PC combinationally.
REQ-025 FSM states INIT, RUN; INIT entered on reset; INIT writes zero to word 0..RAM_DEPTH-1, one word per cycle, regardless of i_enable; after the last word the next state is RUN with o_ready=1 (RAM_DEPTH cycles after reset release).
REQ-026 Word index SHALL be i_ALU_result[log2(RAM_DEPTH)+1:2]; access is legal only if i_ALU_result[1:0]==0 and i_ALU_result[NB_DATA-1:log2(RAM_DEPTH)+2]==0.
REQ-027 In RUN with i_enable=1: MemWrite and legal -> RAM word written with i_read_data_2 at the edge.
REQ-028 In RUN with i_enable=1: MemRead and legal -> o_read_data = RAM word after the same edge (1-cycle latency, read-before-write); otherwise o_read_data = 0.
REQ-029 In RUN with i_enable=1: o_ALU_result, o_write_reg and o_control SHALL register the inputs at each edge (latency 1).
REQ-030 Illegal access with MemRead or MemWrite in RUN with i_enable=1 -> no RAM write, o_mem_fault=1 for one cycle.
REQ-031 In INIT: pipeline writes ignored, o_control forced to 0, o_read_data=0, o_mem_fault=0.
REQ-032 i_enable=0: all registered outputs hold, no RAM write, o_mem_fault=0.

Reset
REQ-033 On i_rst=0 at an edge: o_read_data, o_ALU_result, o_write_reg, o_control, o_mem_fault=0; o_ready=0; init counter=0; state=INIT.
REQ-034 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from word 0.

Configuration
REQ-035 Macro SEG_MEMORY_DEBUG_PORT_EN defined: adds i_dbg_addr (log2(RAM_DEPTH) bits) and o_dbg_data (NB_DATA), a second synchronous read port with 1-cycle latency, independent of i_enable, returning old data on a same-cycle write.
REQ-036 Macro not defined: these ports and the second read port are absent; all other behaviour is identical.

Structure
REQ-037 Shared package seg_pkg SHALL hold control bit-position constants (RegWrite=4, MemtoReg=3, Branch=2, MemRead=1, MemWrite=0) and the INIT/RUN state encoding.
REQ-038 Data memory SHALL be a sub-module seg_memory_ram (synchronous write, synchronous read, optional second read port).

Verification
REQ-039 Reset, then count cycles -> o_ready rises exactly RAM_DEPTH cycles after release; read of word 255 returns 0.
REQ-040 Store 0xDEADBEEF at addr 0x10, then load addr 0x10 -> o_read_data=0xDEADBEEF one cycle after the load edge.
REQ-041 Store at addr 0x12 (misaligned) or 0x400 (out of range) -> o_mem_fault pulses one cycle, no RAM change, later load returns 0.
REQ-042 Branch=1, i_ALU_zero=1, i_PC=0x40 in RUN -> o_PCSrc=1, o_branch_PC=0x40 same cycle; during INIT -> o_PCSrc=0.
REQ-043 i_enable=0 with MemWrite=1 -> outputs hold, memory unchanged; reset asserted mid-RUN -> o_ready=0 and contents re-cleared.

Source files
------------

// File: rtl/seg_memory_pkg.sv
// Shared constants for the memory pipeline stage: control-bus bit positions
// and the init/run state encoding.
package seg_pkg;

  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } seg_state_t;

endpackage

// File: rtl/seg_memory_ram.sv
// Single-port data RAM with registered read (read-before-write).
// SEG_MEMORY_DEBUG_PORT_EN adds an independent synchronous debug read port.
module seg_memory_ram #(
  parameter int NB_DATA   = 32,
  parameter int RAM_DEPTH = 256,
  parameter int NB_AW     = $clog2(RAM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [NB_AW-1:0]   i_addr,
  input  logic [NB_DATA-1:0] i_wdata,
  output logic [NB_DATA-1:0] o_rdata
`ifdef SEG_MEMORY_DEBUG_PORT_EN
  ,
  input  logic [NB_AW-1:0]   i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data
`endif
);

  logic [NB_DATA-1:0] r_mem [RAM_DEPTH];
  logic [NB_DATA-1:0] r_rdata;

  // Read enable lets the output register hold while the pipeline stalls.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

`ifdef SEG_MEMORY_DEBUG_PORT_EN
  logic [NB_DATA-1:0] r_dbg_data;

  always_ff @(posedge i_clk) begin
    r_dbg_data <= r_mem[i_dbg_addr];
  end

  assign o_dbg_data = r_dbg_data;
`endif

endmodule

// File: rtl/seg_memory.sv
// Memory pipeline stage: clears the data RAM after reset, then serves loads/stores.
// SEG_MEMORY_DEBUG_PORT_EN exposes a second read port on the RAM.
module seg_memory
  import seg_pkg::*;
#(
  parameter int NB_ADDR    = 32,
  parameter int NB_DATA    = 32,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_enable,
  input  logic [NB_ADDR-1:0]              i_PC,
  input  logic [NB_DATA-1:0]              i_ALU_result,
  input  logic                            i_ALU_zero,
  input  logic [NB_DATA-1:0]              i_read_data_2,
  input  logic [4:0]                      i_write_reg,
  input  logic [NB_CTRL_WB+NB_CTRL_M-1:0] i_control,
  output logic                            o_PCSrc,
  output logic [NB_ADDR-1:0]              o_branch_PC,
  output logic [NB_DATA-1:0]              o_read_data,
  output logic [NB_DATA-1:0]              o_ALU_result,
  output logic [4:0]                      o_write_reg,
  output logic [NB_CTRL_WB-1:0]           o_control,
  output logic                            o_mem_fault,
  output logic                            o_ready
`ifdef SEG_MEMORY_DEBUG_PORT_EN
  ,
  input  logic [$clog2(RAM_DEPTH)-1:0]    i_dbg_addr,
  output logic [NB_DATA-1:0]              o_dbg_data
`endif
);

  localparam int NB_AW = $clog2(RAM_DEPTH);

  seg_state_t            r_state;
  logic [NB_AW-1:0]      r_init_cnt;
  logic                  r_ready;
  logic                  r_rd_sel;
  logic [NB_DATA-1:0]    r_alu_result;
  logic [4:0]            r_write_reg;
  logic [NB_CTRL_WB-1:0] r_control;
  logic                  r_mem_fault;

  logic                  w_in_init;
  logic                  w_mem_rd;
  logic                  w_mem_wr;
  logic                  w_legal;
  logic [NB_AW-1:0]      w_word_idx;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [NB_AW-1:0]      w_ram_addr;
  logic [NB_DATA-1:0]    w_ram_wdata;
  logic [NB_DATA-1:0]    w_ram_q;

  assign w_in_init  = (r_state == ST_INIT);
  assign w_mem_rd   = i_control[CTRL_MEMREAD];
  assign w_mem_wr   = i_control[CTRL_MEMWRITE];
  assign w_word_idx = i_ALU_result[NB_AW+1:2];
  // Word aligned and no address bits above the RAM's byte range.
  assign w_legal    = (i_ALU_result[1:0] == 2'b00) &&
                      ((i_ALU_result >> (NB_AW + 2)) == '0);

  assign w_ram_we    = i_rst && (w_in_init || (i_enable && w_mem_wr && w_legal));
  assign w_ram_re    = i_rst && !w_in_init && i_enable && w_mem_rd && w_legal;
  assign w_ram_addr  = w_in_init ? r_init_cnt : w_word_idx;
  assign w_ram_wdata = w_in_init ? '0 : i_read_data_2;

  seg_memory_ram #(
    .NB_DATA   (NB_DATA),
    .RAM_DEPTH (RAM_DEPTH),
    .NB_AW     (NB_AW)
  ) u_ram (
    .i_clk      (i_clk),
    .i_we       (w_ram_we),
    .i_re       (w_ram_re),
    .i_addr     (w_ram_addr),
    .i_wdata    (w_ram_wdata),
    .o_rdata    (w_ram_q)
`ifdef SEG_MEMORY_DEBUG_PORT_EN
    ,
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
`endif
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_ready      <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_alu_result <= '0;
      r_write_reg  <= '0;
      r_control    <= '0;
      r_mem_fault  <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt   <= r_init_cnt + NB_AW'(1);
          r_rd_sel     <= 1'b0;
          r_alu_result <= '0;
          r_write_reg  <= '0;
          r_control    <= '0;
          r_mem_fault  <= 1'b0;
          if (r_init_cnt == NB_AW'(RAM_DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_enable) begin
            r_rd_sel     <= w_mem_rd && w_legal;
            r_alu_result <= i_ALU_result;
            r_write_reg  <= i_write_reg;
            r_control    <= i_control[NB_CTRL_M +: NB_CTRL_WB];
            r_mem_fault  <= (w_mem_rd || w_mem_wr) && !w_legal;
          end else begin
            r_mem_fault  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign o_PCSrc      = i_control[CTRL_BRANCH] && i_ALU_zero && r_ready;
  assign o_branch_PC  = i_PC;
  assign o_read_data  = r_rd_sel ? w_ram_q : '0;
  assign o_ALU_result = r_alu_result;
  assign o_write_reg  = r_write_reg;
  assign o_control    = r_control;
  assign o_mem_fault  = r_mem_fault;
  assign o_ready      = r_ready;

endmodule

// File: tb/tb_seg_memory.sv
// Scoreboard bench for seg_memory: stimulus pushes expected results, a monitor
// pops and compares one cycle after each issued transaction.
module tb_seg_memory;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic [31:0] i_PC;
  logic [31:0] i_ALU_result;
  logic        i_ALU_zero;
  logic [31:0] i_read_data_2;
  logic [4:0]  i_write_reg;
  logic [4:0]  i_control;
  logic        o_PCSrc;
  logic [31:0] o_branch_PC;
  logic [31:0] o_read_data;
  logic [31:0] o_ALU_result;
  logic [4:0]  o_write_reg;
  logic [1:0]  o_control;
  logic        o_mem_fault;
  logic        o_ready;
`ifdef SEG_MEMORY_DEBUG_PORT_EN
  logic [7:0]  i_dbg_addr = 8'd0;
  logic [31:0] o_dbg_data;
`endif

  always #5 clk = ~clk;

  seg_memory dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_PC          (i_PC),
    .i_ALU_result  (i_ALU_result),
    .i_ALU_zero    (i_ALU_zero),
    .i_read_data_2 (i_read_data_2),
    .i_write_reg   (i_write_reg),
    .i_control     (i_control),
    .o_PCSrc       (o_PCSrc),
    .o_branch_PC   (o_branch_PC),
    .o_read_data   (o_read_data),
    .o_ALU_result  (o_ALU_result),
    .o_write_reg   (o_write_reg),
    .o_control     (o_control),
    .o_mem_fault   (o_mem_fault),
    .o_ready       (o_ready)
`ifdef SEG_MEMORY_DEBUG_PORT_EN
    ,
    .i_dbg_addr    (i_dbg_addr),
    .o_dbg_data    (o_dbg_data)
`endif
  );

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [1:0]  ctl;
    logic        flt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   txn_no = 0;
  logic tb_issue = 1'b0;
  logic issued_d = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  always @(posedge clk) issued_d <= tb_issue;

  always @(negedge clk) begin
    if (issued_d) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got empty queue want entry");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        txn_no++;
        $display("txn %0d: rd=%h alu=%h wr=%0d ctl=%b flt=%b (exp rd=%h flt=%b)",
                 txn_no, o_read_data, o_ALU_result, o_write_reg, o_control,
                 o_mem_fault, e.rd, e.flt);
        chk("read_data", o_read_data, e.rd);
        chk("alu_result", o_ALU_result, e.alu);
        chk("write_reg", o_write_reg, e.wr);
        chk("control", o_control, e.ctl);
        chk("mem_fault", o_mem_fault, e.flt);
      end
    end
  end

  task automatic txn(input logic en, input logic [4:0] ctrl, input logic [31:0] alu,
                     input logic [31:0] wd, input logic [4:0] wr,
                     input logic [31:0] erd, input logic [31:0] ealu,
                     input logic [4:0] ewr, input logic [1:0] ectl, input logic ef);
    exp_t e;
    @(posedge clk); #1;
    i_enable      = en;
    i_control     = ctrl;
    i_ALU_result  = alu;
    i_read_data_2 = wd;
    i_write_reg   = wr;
    tb_issue      = 1'b1;
    e.rd = erd; e.alu = ealu; e.wr = ewr; e.ctl = ectl; e.flt = ef;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    tb_issue      = 1'b0;
    i_enable      = 1'b1;
    i_control     = 5'h00;
    i_ALU_result  = 32'h0;
    i_read_data_2 = 32'h0;
    i_write_reg   = 5'd0;
    i_ALU_zero    = 1'b0;
  endtask

  // Drives pipeline traffic that INIT must ignore, counts edges to o_ready.
  task automatic wait_ready(input string nm);
    int  cyc = 0;
    bit  seen = 0;
    i_enable      = 1'b1;
    i_control     = 5'h1F;
    i_ALU_result  = 32'h14;
    i_read_data_2 = 32'h12345678;
    i_write_reg   = 5'd6;
    i_ALU_zero    = 1'b1;
    i_PC          = 32'h40;
    for (int k = 1; k <= 1000 && !seen; k++) begin
      @(posedge clk); #1;
      if (o_ready) begin
        seen = 1;
        cyc  = k;
      end
      if (k == 10) begin
        chk({nm, "_init_pcsrc"}, o_PCSrc, 1'b0);
        chk({nm, "_init_control"}, o_control, 2'b00);
        chk({nm, "_init_read_data"}, o_read_data, 32'h0);
        chk({nm, "_init_fault"}, o_mem_fault, 1'b0);
      end
    end
    chk({nm, "_ready_cycles"}, cyc, 256);
    i_control  = 5'h00;
    i_ALU_zero = 1'b0;
  endtask

  initial begin
    i_rst = 1'b0; i_enable = 1'b1; i_PC = 32'h40; i_ALU_result = 32'h14;
    i_ALU_zero = 1'b1; i_read_data_2 = 32'h12345678; i_write_reg = 5'd6;
    i_control = 5'h1F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_read_data", o_read_data, 32'h0);
    chk("rst_alu", o_ALU_result, 32'h0);
    chk("rst_write_reg", o_write_reg, 5'd0);
    chk("rst_control", o_control, 2'b00);
    chk("rst_fault", o_mem_fault, 1'b0);
    chk("rst_pcsrc", o_PCSrc, 1'b0);
    i_rst = 1'b1;
    wait_ready("boot");

    //   en  ctrl   alu           wdata         wr    exp rd        exp alu       wr    ctl    flt
    txn(1, 5'h12, 32'h3FC, 32'h0,        5'd5, 32'h0,        32'h3FC, 5'd5, 2'b10, 0);
    txn(1, 5'h01, 32'h010, 32'hDEADBEEF, 5'd0, 32'h0,        32'h010, 5'd0, 2'b00, 0);
    txn(1, 5'h1A, 32'h010, 32'h0,        5'd7, 32'hDEADBEEF, 32'h010, 5'd7, 2'b11, 0);
    txn(1, 5'h01, 32'h012, 32'hAAAA5555, 5'd0, 32'h0,        32'h012, 5'd0, 2'b00, 1);
    txn(1, 5'h00, 32'h099, 32'h0,        5'd1, 32'h0,        32'h099, 5'd1, 2'b00, 0);
    txn(1, 5'h01, 32'h400, 32'h11112222, 5'd0, 32'h0,        32'h400, 5'd0, 2'b00, 1);
    txn(1, 5'h02, 32'h010, 32'h0,        5'd2, 32'hDEADBEEF, 32'h010, 5'd2, 2'b00, 0);
    txn(1, 5'h02, 32'h000, 32'h0,        5'd2, 32'h0,        32'h000, 5'd2, 2'b00, 0);
    txn(1, 5'h02, 32'h012, 32'h0,        5'd2, 32'h0,        32'h012, 5'd2, 2'b00, 1);
    txn(1, 5'h02, 32'h014, 32'h0,        5'd2, 32'h0,        32'h014, 5'd2, 2'b00, 0);
    txn(1, 5'h01, 32'h3FC, 32'hCAFEF00D, 5'd0, 32'h0,        32'h3FC, 5'd0, 2'b00, 0);
    txn(1, 5'h02, 32'h3FC, 32'h0,        5'd3, 32'hCAFEF00D, 32'h3FC, 5'd3, 2'b00, 0);
    txn(1, 5'h03, 32'h3FC, 32'h01020304, 5'd4, 32'hCAFEF00D, 32'h3FC, 5'd4, 2'b00, 0);
    txn(1, 5'h12, 32'h3FC, 32'h0,        5'd3, 32'h01020304, 32'h3FC, 5'd3, 2'b10, 0);
    txn(0, 5'h11, 32'h010, 32'hBAD0BAD0, 5'd31, 32'h01020304, 32'h3FC, 5'd3, 2'b10, 0);
    txn(0, 5'h11, 32'h010, 32'hBAD0BAD0, 5'd31, 32'h01020304, 32'h3FC, 5'd3, 2'b10, 0);
    txn(1, 5'h02, 32'h3FE, 32'h0,        5'd9, 32'h0,        32'h3FE, 5'd9, 2'b00, 1);
    txn(0, 5'h01, 32'h3FE, 32'h0,        5'd8, 32'h0,        32'h3FE, 5'd9, 2'b00, 0);
    txn(1, 5'h1A, 32'h010, 32'h0,        5'd2, 32'hDEADBEEF, 32'h010, 5'd2, 2'b11, 0);

    txn(1, 5'h04, 32'h000, 32'h0,        5'd0, 32'h0,        32'h000, 5'd0, 2'b00, 0);
    i_ALU_zero = 1'b1; i_PC = 32'h40; #1;
    chk("branch_pcsrc", o_PCSrc, 1'b1);
    chk("branch_pc", o_branch_PC, 32'h40);
    txn(1, 5'h04, 32'h000, 32'h0,        5'd0, 32'h0,        32'h000, 5'd0, 2'b00, 0);
    i_ALU_zero = 1'b0; #1;
    chk("branch_nozero_pcsrc", o_PCSrc, 1'b0);
    idle();

    i_rst = 1'b0;
    @(posedge clk); #1;
    chk("midrun_rst_ready", o_ready, 1'b0);
    chk("midrun_rst_read_data", o_read_data, 32'h0);
    chk("midrun_rst_alu", o_ALU_result, 32'h0);
    chk("midrun_rst_control", o_control, 2'b00);
    i_control = 5'h04; i_ALU_zero = 1'b1; #1;
    chk("midrun_rst_pcsrc", o_PCSrc, 1'b0);
    i_rst = 1'b1;
    wait_ready("reinit");

    txn(1, 5'h02, 32'h010, 32'h0,        5'd2, 32'h0,        32'h010, 5'd2, 2'b00, 0);
    txn(1, 5'h02, 32'h3FC, 32'h0,        5'd3, 32'h0,        32'h3FC, 5'd3, 2'b00, 0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
